// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: memory request/response channel, PC redirect input
// and the instruction stream toward decode.
//   master : the fetch unit (drives requests and the decode stream)
//   slave  : the environment (memory, redirect source and decode stage)
// Signals:
//   mem_req_valid/addr, mem_req_ready    fetch request, handshake = valid & ready
//   mem_resp_valid/data                  in-order responses, one per request
//   redirect_valid/pc                    single-cycle PC redirect
//   instr_valid/instr/instr_pc, ready    buffer head toward decode
interface instr_fetch_if #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned INSTR_WIDTH = 32
);
   logic                   mem_req_valid;
   logic [ADDR_WIDTH-1:0]  mem_req_addr;
   logic                   mem_req_ready;
   logic                   mem_resp_valid;
   logic [INSTR_WIDTH-1:0] mem_resp_data;
   logic                   redirect_valid;
   logic [ADDR_WIDTH-1:0]  redirect_pc;
   logic                   instr_valid;
   logic [INSTR_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0]  instr_pc;
   logic                   instr_ready;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid, mem_resp_data,
      input  redirect_valid, redirect_pc,
      output instr_valid, instr, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid, mem_resp_data,
      output redirect_valid, redirect_pc,
      input  instr_valid, instr, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential fetch requests, tracks in-flight
// fetches, buffers responses in a small FIFO toward decode and discards the
// responses of fetches that were overtaken by a PC redirect.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      instr_fetch_if.master (memory request/response, redirect, decode)
module instr_fetch #(
   parameter int unsigned            ADDR_WIDTH  = 64,
   parameter int unsigned            INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
   parameter int unsigned            DEPTH       = 2
) (
   input logic           clk,
   input logic           reset_n,
   instr_fetch_if.master bus
);

   localparam int unsigned     CW       = $clog2(DEPTH) + 1;
   localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
   logic [CW-1:0]          outstanding_q, outstanding_d;
   logic [CW-1:0]          stale_q, stale_d;
   logic [CW-1:0]          count_q, count_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [INSTR_WIDTH-1:0] buf_instr_q [DEPTH];
   logic [ADDR_WIDTH-1:0]  buf_pc_q    [DEPTH];

   logic                   credit_ok;
   logic                   req_valid;
   logic                   req_hs;
   logic                   resp_take;
   logic                   resp_drop;
   logic                   push;
   logic                   pop;
   logic                   head_valid;
   logic [ADDR_WIDTH-1:0]  redirect_tgt;
   logic [1:0]             unused_redirect_lsbs;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign redirect_tgt         = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign unused_redirect_lsbs = bus.redirect_pc[1:0];

   // Every slot is either in flight or buffered, so this credit rule keeps
   // the FIFO from ever overflowing.
   assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
   assign head_valid = (count_q != '0);

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      stale_d       = stale_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      req_valid     = 1'b0;
      req_hs        = 1'b0;
      resp_take     = 1'b0;
      resp_drop     = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;

      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end

         RUN: begin
            req_valid = credit_ok;
            req_hs    = req_valid && bus.mem_req_ready;
            // A response with nothing in flight is a protocol error: ignore it.
            resp_take = bus.mem_resp_valid && (outstanding_q != '0);
            if (bus.redirect_valid) begin
               // Everything still in flight after this edge belongs to the old
               // path, including a request accepted in this very cycle.
               fetch_pc_d    = redirect_tgt;
               resp_pc_d     = redirect_tgt;
               stale_d       = outstanding_q + CW'(req_hs) - CW'(resp_take);
               outstanding_d = '0;
               count_d       = '0;
               wr_ptr_d      = '0;
               rd_ptr_d      = '0;
               state_d       = (stale_d != '0) ? FLUSH : RUN;
            end else begin
               push          = resp_take;
               pop           = head_valid && bus.instr_ready;
               outstanding_d = outstanding_q + CW'(req_hs) - CW'(resp_take);
               count_d       = count_q + CW'(push) - CW'(pop);
               if (req_hs) begin
                  fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
               end
               if (push) begin
                  resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
                  wr_ptr_d  = ptr_inc(wr_ptr_q);
               end
               if (pop) begin
                  rd_ptr_d = ptr_inc(rd_ptr_q);
               end
            end
         end

         FLUSH: begin
            resp_drop = bus.mem_resp_valid && (stale_q != '0);
            stale_d   = stale_q - CW'(resp_drop);
            // Nothing new is issued here, so every in-flight fetch stays stale
            // across a further redirect; only the target moves.
            if (bus.redirect_valid) begin
               fetch_pc_d = redirect_tgt;
               resp_pc_d  = redirect_tgt;
            end
            state_d = (stale_d == '0) ? RUN : FLUSH;
         end

         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         stale_q       <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc_q[i]    <= '0;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         if (push) begin
            buf_instr_q[wr_ptr_q] <= bus.mem_resp_data;
            buf_pc_q[wr_ptr_q]    <= resp_pc_q;
         end
      end
   end

   assign bus.mem_req_valid = req_valid;
   assign bus.mem_req_addr  = fetch_pc_q;
   assign bus.instr_valid   = head_valid;
   assign bus.instr         = buf_instr_q[rd_ptr_q];
   assign bus.instr_pc      = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: an in-order memory with random latency, random
// decode back-pressure and random redirects, checked against a
// transaction-level model of the fetch stream (next fetch address, next
// delivered PC, in-flight and buffered counts, stale fetches).
module tb_instr_fetch;
   localparam int unsigned    AW       = 64;
   localparam int unsigned    IW       = 32;
   localparam int unsigned    DEPTH    = 2;
   localparam logic [AW-1:0]  RESET_PC = 64'h0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

   instr_fetch #(
      .ADDR_WIDTH (AW),
      .INSTR_WIDTH(IW),
      .RESET_PC   (RESET_PC),
      .DEPTH      (DEPTH)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
      bit            stale;
   } req_t;

   req_t          mem_q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc;
   bit            boot;
   int            buffered;
   int            hs_total;
   logic [AW-1:0] mfetch, mdeliver;

   int            ready_pct, irdy_pct, redir_pct, lat_min, lat_max;
   int            force_redir_cyc;
   logic [AW-1:0] force_tgt;

   bit            ev_hs, ev_resp, ev_pop, ev_redir;
   logic [AW-1:0] ev_addr, ev_tgt;

   logic          log_valid [16];
   logic          log_ivalid[16];
   logic [AW-1:0] log_addr  [16];
   logic [AW-1:0] log_ipc   [16];

   function automatic logic [IW-1:0] inst_word(input logic [AW-1:0] a);
      return a[31:0] ^ 32'hC0DE_0013 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Compare outputs with the model and record this cycle's handshakes.
   task automatic sample();
      int live;
      bit any_stale;
      bit exp_valid;
      live = 0;
      any_stale = 0;
      foreach (mem_q[i]) begin
         if (mem_q[i].stale) any_stale = 1;
         else live++;
      end
      exp_valid = !boot && !any_stale && ((live + buffered) < DEPTH);
      check("req_valid", AW'(bus.mem_req_valid), AW'(exp_valid));
      if (bus.mem_req_valid) check("req_addr", bus.mem_req_addr, mfetch);
      check("instr_valid", AW'(bus.instr_valid), AW'(buffered != 0));
      if (bus.instr_valid) begin
         check("instr_pc", bus.instr_pc, mdeliver);
         check("instr", AW'(bus.instr), AW'(inst_word(mdeliver)));
      end
      if (cyc < 16) begin
         log_valid[cyc]  = bus.mem_req_valid;
         log_addr[cyc]   = bus.mem_req_addr;
         log_ivalid[cyc] = bus.instr_valid;
         log_ipc[cyc]    = bus.instr_pc;
      end
      ev_hs    = bus.mem_req_valid && bus.mem_req_ready;
      ev_addr  = bus.mem_req_addr;
      ev_resp  = bus.mem_resp_valid;
      ev_pop   = bus.instr_valid && bus.instr_ready;
      ev_redir = bus.redirect_valid;
      ev_tgt   = {bus.redirect_pc[AW-1:2], 2'b00};
   endtask

   task automatic update_model();
      req_t e;
      if (ev_resp && mem_q.size() > 0) begin
         e = mem_q.pop_front();
         if (!e.stale && !ev_redir) buffered++;
      end
      if (ev_pop && !ev_redir) begin
         buffered--;
         mdeliver += 4;
      end
      if (ev_redir) begin
         buffered = 0;
         foreach (mem_q[i]) mem_q[i].stale = 1;
         mfetch   = ev_tgt;
         mdeliver = ev_tgt;
      end
      if (ev_hs) begin
         hs_total++;
         e.addr  = ev_addr;
         e.due   = cyc + int'($urandom_range(lat_max, lat_min));
         e.stale = ev_redir;
         mem_q.push_back(e);
         if (!ev_redir) mfetch += 4;
      end
      boot = 0;
   endtask

   task automatic drive();
      bus.mem_req_ready = ($urandom_range(99) < ready_pct);
      bus.instr_ready   = ($urandom_range(99) < irdy_pct);
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = inst_word(mem_q[0].addr);
      end else begin
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_data  = $urandom;
      end
      if (cyc == force_redir_cyc) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = force_tgt;
      end else if ($urandom_range(99) < redir_pct) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = AW'($urandom_range(65535, 0));
      end else begin
         bus.redirect_valid = 1'b0;
         bus.redirect_pc    = AW'($urandom);
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         update_model();
         cyc++;
         drive();
         @(negedge clk);
         sample();
      end
   endtask

   // Leaves the bench at the negedge of cycle 0 (the first cycle out of reset).
   task automatic do_reset();
      reset_n            = 1'b0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.instr_ready    = 1'b0;
      mem_q.delete();
      buffered        = 0;
      hs_total        = 0;
      mfetch          = RESET_PC;
      mdeliver        = RESET_PC;
      boot            = 1;
      cyc             = 0;
      force_redir_cyc = -1;
      for (int i = 0; i < 16; i++) begin
         log_valid[i]  = 1'b0;
         log_ivalid[i] = 1'b0;
         log_addr[i]   = '1;
         log_ipc[i]    = '1;
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      sample();
   endtask

   task automatic knobs(input int rdy, input int irdy, input int redir, input int lmin, input int lmax);
      ready_pct = rdy;
      irdy_pct  = irdy;
      redir_pct = redir;
      lat_min   = lmin;
      lat_max   = lmax;
   endtask

   initial begin
      // Start-up timing with latency 1, then an asynchronous reset with one
      // instruction buffered and one fetch in flight.
      knobs(100, 0, 0, 1, 1);
      do_reset();
      run_cycles(3);
      check("boot_valid0", AW'(log_valid[0]), AW'(0));
      check("start_valid1", AW'(log_valid[1]), AW'(1));
      check("start_addr1", log_addr[1], 64'h0);
      check("start_addr2", log_addr[2], 64'h4);
      check("start_ivalid3", AW'(log_ivalid[3]), AW'(1));
      check("start_ipc3", log_ipc[3], 64'h0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_req_valid", AW'(bus.mem_req_valid), AW'(0));
      check("arst_instr_valid", AW'(bus.instr_valid), AW'(0));
      check("arst_instr", AW'(bus.instr), AW'(0));
      check("arst_instr_pc", bus.instr_pc, 64'h0);
      check("arst_req_addr", bus.mem_req_addr, RESET_PC);
      do_reset();
      run_cycles(1);
      check("post_rst_valid", AW'(log_valid[1]), AW'(1));
      check("post_rst_addr", log_addr[1], RESET_PC);

      // Decode stalled: only DEPTH fetches may be issued until a pop.
      knobs(100, 0, 0, 1, 2);
      do_reset();
      run_cycles(10);
      check("stall_hs_count", AW'(hs_total), AW'(2));
      check("stall_valid9", AW'(log_valid[9]), AW'(0));
      irdy_pct = 100;
      run_cycles(2);
      check("stall_valid11", AW'(log_valid[11]), AW'(0));
      check("resume_valid12", AW'(log_valid[12]), AW'(1));
      check("resume_addr12", log_addr[12], 64'h8);

      // Memory not ready for 5 cycles: address held, then a single advance.
      knobs(0, 100, 0, 1, 1);
      do_reset();
      run_cycles(5);
      for (int c = 1; c <= 5; c++) begin
         check("hold_valid", AW'(log_valid[c]), AW'(1));
         check("hold_addr", log_addr[c], 64'h0);
      end
      ready_pct = 100;
      run_cycles(1);
      ready_pct = 0;
      run_cycles(1);
      check("hold_hs_count", AW'(hs_total), AW'(1));
      check("hold_addr7", log_addr[7], 64'h4);

      // Redirect to an unaligned target with two fetches in flight.
      knobs(100, 100, 0, 4, 4);
      do_reset();
      force_redir_cyc = 3;
      force_tgt       = 64'h1002;
      run_cycles(8);
      check("flush_valid3", AW'(log_valid[3]), AW'(0));
      for (int c = 4; c <= 6; c++) begin
         check("flush_ivalid", AW'(log_ivalid[c]), AW'(0));
         check("flush_req_valid", AW'(log_valid[c]), AW'(0));
      end
      check("flush_exit_valid", AW'(log_valid[7]), AW'(1));
      check("flush_exit_addr", log_addr[7], 64'h1000);

      // Redirect together with a response and a request handshake.
      knobs(100, 100, 0, 1, 1);
      do_reset();
      force_redir_cyc = 2;
      force_tgt       = 64'h2000;
      run_cycles(6);
      check("race_ivalid3", AW'(log_ivalid[3]), AW'(0));
      check("race_valid3", AW'(log_valid[3]), AW'(0));
      check("race_ivalid4", AW'(log_ivalid[4]), AW'(0));
      check("race_valid4", AW'(log_valid[4]), AW'(1));
      check("race_addr4", log_addr[4], 64'h2000);
      check("race_ivalid6", AW'(log_ivalid[6]), AW'(1));
      check("race_ipc6", log_ipc[6], 64'h2000);

      // Randomised traffic.
      knobs(70, 60, 4, 1, 4);
      do_reset();
      run_cycles(3000);
      knobs(40, 90, 8, 1, 3);
      do_reset();
      run_cycles(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
